// File: rtl/pb_pkg.sv
// pb_pkg: shared definitions for the protobuf key encoder.
// Holds the wire-type codes, the encoder state enum and the varint size
// limit for a 32-bit key.
package pb_pkg;

  localparam logic [2:0] WT_VARINT = 3'd0;
  localparam logic [2:0] WT_I64    = 3'd1;
  localparam logic [2:0] WT_LEN    = 3'd2;
  localparam logic [2:0] WT_SGROUP = 3'd3;
  localparam logic [2:0] WT_EGROUP = 3'd4;
  localparam logic [2:0] WT_I32    = 3'd5;

  localparam int VARINT_MAX_BYTES = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEY  = 2'd1,
    ST_LEN  = 2'd2
  } enc_state_e;

endpackage

// File: rtl/key_encoder_varint_byte.sv
// varint_byte: combinational base-128 byte former.
// Ports:
//   sr   in  W : shift register holding the not-yet-emitted value bits
//   more out 1 : bits remain above the low 7 (continuation needed)
//   data out 8 : {more, sr[6:0]}
module varint_byte #(
  parameter int W = 32
) (
  input  logic [W-1:0] sr,
  output logic         more,
  output logic [7:0]   data
);

  assign more = |sr[W-1:7];
  assign data = {more, sr[6:0]};

endmodule

// File: rtl/key_encoder.sv
// key_encoder: serializes a protobuf field key ((field << 3) | wire_type)
// as a little-endian varint, followed by the length varint for
// length-delimited fields. One byte per cycle.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   io_in_valid/ready     : request handshake (ready = idle)
//   io_field_number       : field number, legal 1..2^FIELD_W-1
//   io_wire_type          : wire type, legal 0..5
//   io_value_size         : payload length, used only for wire type 2
//   io_out_valid/ready    : byte handshake toward the output FIFO
//   io_out_data           : varint byte, bit7 = continuation
//   io_out_last           : final byte of the request
//   io_bytes_written      : bytes accepted downstream for the current request
//   io_err                : one-cycle pulse for a rejected request
//   dbg_state             : current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once valid is raised it stays high, with data/last stable, until
// that transfer happens; ready may change freely.
module key_encoder
  import pb_pkg::*;
#(
  parameter int FIELD_W = 29,
  parameter int LEN_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_in_valid,
  output logic               io_in_ready,
  input  logic [FIELD_W-1:0] io_field_number,
  input  logic [2:0]         io_wire_type,
  input  logic [LEN_W-1:0]   io_value_size,
  output logic               io_out_valid,
  input  logic               io_out_ready,
  output logic [7:0]         io_out_data,
  output logic               io_out_last,
  output logic [3:0]         io_bytes_written,
  output logic               io_err,
  output logic [1:0]         dbg_state
);

  localparam int KEY_W = FIELD_W + 3;
  localparam int SR_W  = (KEY_W > LEN_W) ? KEY_W : LEN_W;

  enc_state_e       state_q, state_d;
  logic [KEY_W-1:0] key_sr_q, key_sr_d;
  logic [LEN_W-1:0] len_sr_q, len_sr_d;
  logic             is_len_q, is_len_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             err_q, err_d;

  // The byte former looks at the shift register the next cycle will present,
  // so the registered data/last always describe the byte currently on offer.
  logic [SR_W-1:0]  sr_next;
  logic             more_next;
  logic [7:0]       data_next;

  logic             cur_more;
  logic             illegal;

  // The presented byte's continuation bit is its "more" flag.
  assign cur_more = out_data_q[7];
  assign illegal  = (io_field_number == '0) || (io_wire_type > WT_I32);

  always_comb begin
    state_d    = state_q;
    key_sr_d   = key_sr_q;
    len_sr_d   = len_sr_q;
    is_len_d   = is_len_q;
    cnt_d      = cnt_q;
    in_ready_d = in_ready_q;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        if (io_in_valid && in_ready_q) begin
          key_sr_d = {io_field_number, io_wire_type};
          is_len_d = (io_wire_type == WT_LEN);
          len_sr_d = (io_wire_type == WT_LEN) ? io_value_size : '0;
          cnt_d    = '0;
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            state_d    = ST_KEY;
            in_ready_d = 1'b0;
          end
        end
      end
      ST_KEY: begin
        if (io_out_ready) begin
          key_sr_d = key_sr_q >> 7;
          cnt_d    = cnt_q + 4'd1;
          if (!cur_more) begin
            if (is_len_q) begin
              state_d = ST_LEN;
            end else begin
              state_d    = ST_IDLE;
              in_ready_d = 1'b1;
            end
          end
        end
      end
      ST_LEN: begin
        if (io_out_ready) begin
          len_sr_d = len_sr_q >> 7;
          cnt_d    = cnt_q + 4'd1;
          if (!cur_more) begin
            state_d    = ST_IDLE;
            in_ready_d = 1'b1;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  assign sr_next = (state_d == ST_LEN) ? SR_W'(len_sr_d) : SR_W'(key_sr_d);

  varint_byte #(.W(SR_W)) u_varint_byte (
    .sr   (sr_next),
    .more (more_next),
    .data (data_next)
  );

  always_comb begin
    out_valid_d = (state_d != ST_IDLE);
    out_data_d  = out_valid_d ? data_next : 8'h00;
    // A key byte is only last when no length varint follows it.
    out_last_d  = out_valid_d && !more_next && !((state_d == ST_KEY) && is_len_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      key_sr_q    <= '0;
      len_sr_q    <= '0;
      is_len_q    <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_sr_q    <= key_sr_d;
      len_sr_q    <= len_sr_d;
      is_len_q    <= is_len_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign io_in_ready      = in_ready_q;
  assign io_out_valid     = out_valid_q;
  assign io_out_data      = out_data_q;
  assign io_out_last      = out_last_q;
  assign io_bytes_written = cnt_q;
  assign io_err           = err_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_key_encoder.sv
// tb_key_encoder: table vectors from the test plan, hand-written corner
// sequences (illegal requests, reset mid-message) and randomized requests
// checked against an arithmetic varint model.
module tb_key_encoder;

  logic        clock;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [28:0] io_field_number;
  logic [2:0]  io_wire_type;
  logic [15:0] io_value_size;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [7:0]  io_out_data;
  logic        io_out_last;
  logic [3:0]  io_bytes_written;
  logic        io_err;
  logic [1:0]  dbg_state;

  key_encoder dut (
    .clock            (clock),
    .reset            (reset),
    .io_in_valid      (io_in_valid),
    .io_in_ready      (io_in_ready),
    .io_field_number  (io_field_number),
    .io_wire_type     (io_wire_type),
    .io_value_size    (io_value_size),
    .io_out_valid     (io_out_valid),
    .io_out_ready     (io_out_ready),
    .io_out_data      (io_out_data),
    .io_out_last      (io_out_last),
    .io_bytes_written (io_bytes_written),
    .io_err           (io_err),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: base-128 digits of the key, then of the length for wire type 2.
  task automatic model(input longint unsigned field, input int unsigned wt, input longint unsigned len);
    longint unsigned v;
    v = field * 8 + wt;
    do begin
      exp_q.push_back(8'(v % 128) | ((v >= 128) ? 8'h80 : 8'h00));
      v = v / 128;
    end while (v != 0);
    if (wt == 2) begin
      v = len;
      do begin
        exp_q.push_back(8'(v % 128) | ((v >= 128) ? 8'h80 : 8'h00));
        v = v / 128;
      end while (v != 0);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All inputs change and all outputs are sampled on the falling edge.
  task automatic do_reset();
    reset = 1'b1;
    io_in_valid = 1'b0;
    io_out_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !io_in_ready; i++) @(negedge clock);
    check("wait_in_ready", io_in_ready, 1);
  endtask

  task automatic issue(input logic [28:0] f, input logic [2:0] w, input logic [15:0] l);
    io_in_valid     = 1'b1;
    io_field_number = f;
    io_wire_type    = w;
    io_value_size   = l;
    @(negedge clock);
    io_in_valid = 1'b0;
  endtask

  // mode 0: ready held high; 1: ready alternates starting low; 2: random.
  // noise: hold in_valid high with garbage while busy (must be ignored).
  task automatic collect(input int mode, input bit noise);
    int   n_exp;
    int   cyc;
    bit   stalled;
    logic [7:0] sd;
    logic sl;
    logic rdy;
    logic [7:0] eb;
    n_exp = exp_q.size();
    cyc = 0;
    stalled = 0;
    sd = '0;
    sl = 1'b0;
    check("first_valid", io_out_valid, 1);
    check("busy_in_ready", io_in_ready, 0);
    while (exp_q.size() > 0 && cyc < 64) begin
      if (!io_out_valid) begin
        check("valid_midmsg", io_out_valid, 1);
        break;
      end
      if (stalled) begin
        check("stall_data", io_out_data, sd);
        check("stall_last", io_out_last, sl);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2) == 1;
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      io_out_ready = rdy;
      if (rdy) begin
        eb = exp_q.pop_front();
        check("byte_data", io_out_data, eb);
        check("byte_last", io_out_last, exp_q.size() == 0);
        stalled = 0;
      end else begin
        stalled = 1;
        sd = io_out_data;
        sl = io_out_last;
      end
      if (noise) begin
        io_in_valid     = 1'b1;
        io_field_number = 29'($urandom);
        io_wire_type    = 3'($urandom);
        io_value_size   = 16'($urandom);
      end
      @(negedge clock);
      cyc++;
    end
    io_out_ready = 1'b0;
    io_in_valid  = 1'b0;
    if (exp_q.size() != 0) check("byte_timeout", exp_q.size(), 0);
    exp_q.delete();
    if (mode == 0) check("throughput_cycles", cyc, n_exp);
    check("done_in_ready", io_in_ready, 1);
    check("done_out_valid", io_out_valid, 0);
    check("bytes_written", io_bytes_written, n_exp);
  endtask

  // ---------------- stimulus table ----------------
  typedef struct {
    logic [28:0] f;
    logic [2:0]  w;
    logic [15:0] l;
    int          mode;
    int          n;
    logic [63:0] b; // first byte in bits 7:0
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [28:0] f;
    logic [2:0]  w;
    logic [15:0] l;
    int nb;

    io_in_valid = 1'b0;
    io_field_number = '0;
    io_wire_type = '0;
    io_value_size = '0;
    io_out_ready = 1'b0;
    reset = 1'b1;

    vecs[0] = '{29'd1,         3'd0, 16'd0,     0, 1, 64'h08};
    vecs[1] = '{29'd16,        3'd2, 16'd300,   0, 4, 64'h02AC0182};
    vecs[2] = '{29'h1FFFFFFF,  3'd5, 16'd0,     0, 5, 64'h0FFFFFFFFD};
    vecs[3] = '{29'h1FFFFFFF,  3'd5, 16'd0,     1, 5, 64'h0FFFFFFFFD};
    vecs[4] = '{29'd15,        3'd2, 16'd0,     0, 2, 64'h007A};
    vecs[5] = '{29'd15,        3'd2, 16'd65535, 0, 4, 64'h03FFFF7A};
    vecs[6] = '{29'd1,         3'd2, 16'd128,   0, 3, 64'h01800A};
    vecs[7] = '{29'd1,         3'd1, 16'd99,    0, 1, 64'h09};
    vecs[8] = '{29'd300,       3'd0, 16'd0,     1, 2, 64'h12E0};

    // Reset state.
    repeat (2) @(negedge clock);
    check("rst_in_ready", io_in_ready, 0);
    check("rst_out_valid", io_out_valid, 0);
    check("rst_out_data", io_out_data, 0);
    check("rst_out_last", io_out_last, 0);
    check("rst_bytes", io_bytes_written, 0);
    check("rst_err", io_err, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready", io_in_ready, 1);

    // Table vectors.
    for (int i = 0; i < 9; i++) begin
      wait_ready();
      for (int k = 0; k < vecs[i].n; k++) exp_q.push_back(vecs[i].b[8*k +: 8]);
      issue(vecs[i].f, vecs[i].w, vecs[i].l);
      collect(vecs[i].mode, 1'b0);
    end

    // Illegal requests: field 0, then wire type 6, then a normal request
    // accepted in the cycle right after the error pulse.
    wait_ready();
    issue(29'd0, 3'd0, 16'd0);
    check("ill0_err", io_err, 1);
    check("ill0_ready", io_in_ready, 1);
    check("ill0_valid", io_out_valid, 0);
    check("ill0_bytes", io_bytes_written, 0);
    issue(29'd3, 3'd6, 16'd0);
    check("ill6_err", io_err, 1);
    check("ill6_ready", io_in_ready, 1);
    check("ill6_valid", io_out_valid, 0);
    model(16, 2, 300);
    issue(29'd16, 3'd2, 16'd300);
    check("after_ill_err", io_err, 0);
    collect(0, 1'b0);

    // Reset after the second byte's handshake of the len-300 message.
    wait_ready();
    issue(29'd16, 3'd2, 16'd300);
    io_out_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("pre_rst_data", io_out_data, 8'hAC);
    reset = 1'b1;
    io_out_ready = 1'b0;
    @(negedge clock);
    check("midrst_valid", io_out_valid, 0);
    check("midrst_data", io_out_data, 0);
    check("midrst_last", io_out_last, 0);
    check("midrst_err", io_err, 0);
    check("midrst_bytes", io_bytes_written, 0);
    check("midrst_ready", io_in_ready, 0);
    reset = 1'b0;
    @(negedge clock);
    wait_ready();
    exp_q.push_back(8'h08);
    issue(29'd1, 3'd0, 16'd0);
    collect(0, 1'b0);

    // Randomized legal requests against the model.
    for (int i = 0; i < 60; i++) begin
      nb = $urandom_range(1, 29);
      f = 29'($urandom >> (32 - nb));
      if (f == 0) f = 29'd1;
      w = 3'($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) w = 3'd2;
      nb = $urandom_range(0, 16);
      l = (nb == 0) ? 16'd0 : 16'($urandom >> (32 - nb));
      wait_ready();
      model(f, w, l);
      issue(f, w, l);
      collect($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
